// File: rtl/zeroriscy_bnn_seq.sv
// BNN vector sequencer: fetches count operand words from data memory, runs each
// through the single-operation BNN unit and accumulates the results.
module zeroriscy_bnn_seq #(
    parameter int          CNT_WIDTH   = 8,
    parameter logic [31:0] ADDR_STRIDE = 32'd4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [2:0]           op_i,
    input  logic [31:0]          base_addr_i,
    input  logic [CNT_WIDTH-1:0] count_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [31:0]          result_o,
    output logic                 data_req_o,
    output logic [31:0]          data_addr_o,
    input  logic                 data_gnt_i,
    input  logic                 data_rvalid_i,
    input  logic [31:0]          data_rdata_i,
    output logic                 bnn_en_o,
    output logic [2:0]           bnn_operator_o,
    output logic [31:0]          bnn_addr_o,
    output logic [31:0]          bnn_data_o,
    input  logic                 bnn_ready_i,
    input  logic [31:0]          bnn_result_i
);

    // Handshakes: data_req_o is held with a stable address until a cycle with
    // data_gnt_i; exactly one data_rvalid_i follows each grant, possibly in the very next
    // cycle. bnn_en_o is held with stable operator/address/operand until bnn_ready_i.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT_R = 3'd2,
        EXEC   = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_e;

    state_e               state_q;
    logic [2:0]           op_q;
    logic [31:0]          addr_q;
    logic [31:0]          operand_q;
    logic [31:0]          acc_q;
    logic [31:0]          result_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] idx_q;
    logic [CNT_WIDTH-1:0] idx_inc;
    logic [31:0]          acc_next;
    logic                 last_elem;

    assign idx_inc   = idx_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    assign last_elem = (idx_inc == count_q);
    assign acc_next  = acc_q + bnn_result_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            operand_q <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            count_q   <= '0;
            idx_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        result_q <= '0;
                        if (count_i != '0) begin
                            op_q    <= op_i;
                            addr_q  <= base_addr_i;
                            count_q <= count_i;
                            acc_q   <= '0;
                            idx_q   <= '0;
                            state_q <= FETCH;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                FETCH: begin
                    // A granted request still owes a response, so an abort must drain it.
                    if (abort_i) begin
                        state_q <= data_gnt_i ? DRAIN : IDLE;
                    end else if (data_gnt_i) begin
                        state_q <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (data_rvalid_i) begin
                        if (abort_i) begin
                            state_q <= IDLE;
                        end else begin
                            operand_q <= data_rdata_i;
                            state_q   <= EXEC;
                        end
                    end else if (abort_i) begin
                        state_q <= DRAIN;
                    end
                end
                EXEC: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                    end else if (bnn_ready_i) begin
                        acc_q <= acc_next;
                        idx_q <= idx_inc;
                        if (last_elem) begin
                            result_q <= acc_next;
                            state_q  <= DONE;
                        end else begin
                            addr_q  <= addr_q + ADDR_STRIDE;
                            state_q <= FETCH;
                        end
                    end
                end
                DRAIN: begin
                    if (data_rvalid_i) begin
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);
    assign result_o       = result_q;
    assign data_req_o     = (state_q == FETCH);
    assign data_addr_o    = addr_q;
    assign bnn_en_o       = (state_q == EXEC);
    assign bnn_operator_o = op_q;
    assign bnn_addr_o     = addr_q;
    assign bnn_data_o     = operand_q;

endmodule

// File: tb/tb_zeroriscy_bnn_seq.sv
// Self-checking bench for zeroriscy_bnn_seq: the bench plays memory and BNN unit
// and checks addresses, operands, result sums and done timing against its own model.
module tb_zeroriscy_bnn_seq;

    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic [2:0]    op_i;
    logic [31:0]   base_addr_i;
    logic [CW-1:0] count_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic [31:0]   result_o;
    logic          data_req_o;
    logic [31:0]   data_addr_o;
    logic          data_gnt_i;
    logic          data_rvalid_i;
    logic [31:0]   data_rdata_i;
    logic          bnn_en_o;
    logic [2:0]    bnn_operator_o;
    logic [31:0]   bnn_addr_o;
    logic [31:0]   bnn_data_o;
    logic          bnn_ready_i;
    logic [31:0]   bnn_result_i;

    zeroriscy_bnn_seq #(.CNT_WIDTH(CW), .ADDR_STRIDE(32'd4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .op_i           (op_i),
        .base_addr_i    (base_addr_i),
        .count_i        (count_i),
        .abort_i        (abort_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .result_o       (result_o),
        .data_req_o     (data_req_o),
        .data_addr_o    (data_addr_o),
        .data_gnt_i     (data_gnt_i),
        .data_rvalid_i  (data_rvalid_i),
        .data_rdata_i   (data_rdata_i),
        .bnn_en_o       (bnn_en_o),
        .bnn_operator_o (bnn_operator_o),
        .bnn_addr_o     (bnn_addr_o),
        .bnn_data_o     (bnn_data_o),
        .bnn_ready_i    (bnn_ready_i),
        .bnn_result_i   (bnn_result_i)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    int          gw[256];
    int          rw[256];
    int          bw[256];
    logic [31:0] bnn_res[256];
    bit          seen_done, seen_en, seen_req;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next sampling point and return all strobes to idle.
    task automatic next_cycle();
        @(negedge clk);
        start_i       = 1'b0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        bnn_ready_i   = 1'b0;
        abort_i       = 1'b0;
        data_rdata_i  = $urandom;
        bnn_result_i  = $urandom;
        seen_done |= done_o;
        seen_en   |= bnn_en_o;
        seen_req  |= data_req_o;
    endtask

    task automatic set_env(input int maxw);
        for (int i = 0; i < 256; i++) begin
            gw[i]      = $urandom_range(0, maxw);
            rw[i]      = $urandom_range(0, maxw);
            bw[i]      = $urandom_range(0, maxw);
            bnn_res[i] = $urandom;
        end
    endtask

    // Issue one command and act as memory + BNN until done_o or a cycle budget.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [31:0] base,
                           input int cnt, input bit spurious);
        int          cyc, elem, exp_done, done_cyc, gcnt, rcnt, bcnt;
        int          busy_bad, unstable, reqs, ens, exp_reqs, exp_ens;
        bit          pend, done_seen;
        logic [31:0] exp_sum, cur_addr, hold_addr, res, a;
        logic [66:0] hold_bnn;
        exp_sum  = 0;
        exp_done = 3 * cnt + 1;
        exp_reqs = cnt;
        exp_ens  = cnt;
        exp_q.delete();
        for (int i = 0; i < cnt; i++) begin
            exp_sum  += bnn_res[i];
            exp_done += gw[i] + rw[i] + bw[i];
            exp_reqs += gw[i];
            exp_ens  += bw[i];
            exp_q.push_back(base + 32'(4 * i));
        end
        next_cycle();
        start_i = 1'b1; op_i = op; base_addr_i = base; count_i = CW'(cnt);
        cyc = 0; elem = 0; gcnt = 0; rcnt = 0; bcnt = 0; pend = 0; done_seen = 0;
        busy_bad = 0; unstable = 0; reqs = 0; ens = 0; done_cyc = -1; res = '0;
        cur_addr = '0; hold_addr = '0; hold_bnn = '0;
        while (!done_seen && cyc < 3000) begin
            next_cycle();
            cyc++;
            if (spurious && cyc == 2) begin
                start_i = 1'b1; base_addr_i = 32'hDEAD_0000; count_i = 8'd5;
            end
            if (busy_o !== 1'b1) busy_bad++;
            if (done_o === 1'b1) begin
                done_seen = 1; done_cyc = cyc; res = result_o;
            end else begin
                if (pend) begin
                    if (rcnt == rw[elem]) begin
                        data_rvalid_i = 1'b1; data_rdata_i = mem_word(cur_addr);
                        pend = 0; rcnt = 0;
                    end else rcnt++;
                end
                if (data_req_o === 1'b1) begin
                    reqs++;
                    if (gcnt == 0) hold_addr = data_addr_o;
                    else if (data_addr_o !== hold_addr) unstable++;
                    if (elem < 256 && gcnt == gw[elem]) begin
                        data_gnt_i = 1'b1; gcnt = 0; pend = 1;
                        a = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
                        check({tag, " data_addr"}, data_addr_o, a);
                        cur_addr = a;
                    end else gcnt++;
                end
                if (bnn_en_o === 1'b1) begin
                    ens++;
                    if (bcnt == 0) begin
                        check({tag, " bnn_operator"}, bnn_operator_o, op);
                        check({tag, " bnn_addr"}, bnn_addr_o, cur_addr);
                        check({tag, " bnn_data"}, bnn_data_o, mem_word(cur_addr));
                        hold_bnn = {bnn_operator_o, bnn_addr_o, bnn_data_o};
                    end else if ({bnn_operator_o, bnn_addr_o, bnn_data_o} !== hold_bnn) unstable++;
                    if (elem < 256 && bcnt == bw[elem]) begin
                        bnn_ready_i = 1'b1; bnn_result_i = bnn_res[elem];
                        bcnt = 0; elem++;
                    end else bcnt++;
                end
            end
        end
        check({tag, " done seen"}, done_seen, 1);
        check({tag, " done cycle"}, done_cyc, exp_done);
        check({tag, " result"}, res, exp_sum);
        check({tag, " busy while running"}, busy_bad, 0);
        check({tag, " stable during waits"}, unstable, 0);
        check({tag, " req cycles"}, reqs, exp_reqs);
        check({tag, " bnn_en cycles"}, ens, exp_ens);
        check({tag, " addresses left"}, exp_q.size(), 0);
        next_cycle();
        check({tag, " idle after done"}, {busy_o, done_o}, 2'b00);
        check({tag, " result held"}, result_o, exp_sum);
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; op_i = '0; base_addr_i = '0; count_i = '0;
        abort_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        bnn_ready_i = 1'b0; bnn_result_i = '0;
        seen_done = 0; seen_en = 0; seen_req = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset ctrl", {busy_o, done_o, data_req_o, bnn_en_o, bnn_operator_o}, 7'd0);
        check("reset result", result_o, 0);
        check("reset addrs", {data_addr_o, bnn_addr_o}, 64'd0);
        check("reset bnn_data", bnn_data_o, 0);

        // directed: three elements, zero-wait, results 5/7/9
        set_env(0);
        for (int i = 0; i < 256; i++) begin gw[i] = 0; rw[i] = 0; bw[i] = 0; end
        bnn_res[0] = 32'd5; bnn_res[1] = 32'd7; bnn_res[2] = 32'd9;
        run_cmd("basic3", 3'd3, 32'h0000_1000, 3, 1'b0);

        // count = 0 completes at once with nothing issued
        run_cmd("count0", 3'd2, 32'h0000_4000, 0, 1'b0);

        // gnt delayed 2 and bnn_ready delayed 3 on element 0
        gw[0] = 2; bw[0] = 3;
        run_cmd("waits", 3'd6, 32'h0000_8000, 2, 1'b0);
        gw[0] = 0; bw[0] = 0;

        // accumulator wrap, with a start pulse while busy
        bnn_res[0] = 32'hFFFF_FFFF; bnn_res[1] = 32'h0000_0002;
        run_cmd("wrap", 3'd1, 32'h0000_0100, 2, 1'b1);

        // abort after gnt: DRAIN swallows the late rvalid
        seen_done = 0; seen_en = 0;
        next_cycle(); start_i = 1'b1; op_i = 3'd1; base_addr_i = 32'h2000; count_i = 8'd4;
        next_cycle(); data_gnt_i = 1'b1;
        check("drain req", data_req_o, 1);
        next_cycle(); abort_i = 1'b1;
        next_cycle();
        check("drain busy", {busy_o, data_req_o}, 2'b10);
        next_cycle(); next_cycle();
        next_cycle(); data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_AAAA;
        check("drain still busy", busy_o, 1);
        next_cycle();
        check("drain idle", busy_o, 0);
        check("drain result", result_o, 0);
        next_cycle();
        check("drain no done/en", {seen_done, seen_en}, 2'b00);

        // abort in FETCH without gnt
        next_cycle(); start_i = 1'b1; op_i = 3'd2; base_addr_i = 32'h3000; count_i = 8'd3;
        next_cycle(); abort_i = 1'b1;
        next_cycle();
        check("abort fetch idle", {busy_o, data_req_o}, 2'b00);

        // abort wins over same-cycle completion in EXEC
        seen_done = 0;
        next_cycle(); start_i = 1'b1; op_i = 3'd4; base_addr_i = 32'h3100; count_i = 8'd1;
        next_cycle(); data_gnt_i = 1'b1;
        next_cycle(); data_rvalid_i = 1'b1; data_rdata_i = 32'h0BAD_F00D;
        next_cycle(); bnn_ready_i = 1'b1; bnn_result_i = 32'd7; abort_i = 1'b1;
        check("abort exec en", bnn_en_o, 1);
        next_cycle();
        check("abort exec idle", {busy_o, bnn_en_o}, 2'b00);
        next_cycle();
        check("abort exec no done", seen_done, 0);
        check("abort exec result", result_o, 0);

        // reset while in EXEC, then an immediate new start
        next_cycle(); start_i = 1'b1; op_i = 3'd5; base_addr_i = 32'h3000; count_i = 8'd2;
        next_cycle(); data_gnt_i = 1'b1;
        next_cycle(); data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_F00D;
        next_cycle(); rst = 1'b1;
        check("pre-reset en", bnn_en_o, 1);
        next_cycle(); rst = 1'b0;
        check("midrst ctrl", {busy_o, done_o, data_req_o, bnn_en_o, bnn_operator_o}, 7'd0);
        check("midrst addrs", {data_addr_o, bnn_addr_o}, 64'd0);
        check("midrst data/result", {bnn_data_o, result_o}, 64'd0);
        start_i = 1'b1; op_i = 3'd0; count_i = 8'd0;
        next_cycle();
        check("post-reset start", {busy_o, done_o}, 2'b11);

        // randomized commands, including an address range that wraps
        for (int t = 0; t < 8; t++) begin
            set_env(3);
            run_cmd($sformatf("rand%0d", t), 3'($urandom_range(0, 7)),
                    (t == 3) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC),
                    $urandom_range(1, 12), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
